// File: rtl/btn_debounce_repeat.sv
// Debounced push-button with press, step (auto-repeat) and release pulses.
// The FSM advances only on ticks derived from rising edges of the 128 Hz btn_clk,
// so every counter below counts button samples, not system clocks.
module btn_debounce_repeat #(
    parameter int STABLE_SAMPLES = 4,
    parameter int REPEAT_DELAY   = 64,
    parameter int REPEAT_PERIOD  = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_clk,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic step_pulse,
    output logic release_pulse
);

    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int DB_W    = $clog2(STABLE_SAMPLES + 1);
    localparam int REP_W   = $clog2(REP_MAX + 1);

    // Terminal values: the transition fires when the count is one short of the target,
    // since the current sample is the one that completes it.
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(STABLE_SAMPLES - 1);
    localparam logic [REP_W-1:0] DLY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PER_LAST = REP_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

    logic [2:0]       bclk_sync;
    logic [1:0]       raw_sync;
    logic             tick;
    logic             sample;
    state_t           state, state_nxt;
    logic [DB_W-1:0]  db_cnt, db_cnt_nxt;
    logic [REP_W-1:0] rep_cnt, rep_cnt_nxt;
    logic             first, first_nxt;
    logic             level_nxt, press_nxt, step_nxt, release_nxt;

    // Synchronize btn_clk/btn_raw and register the edge-detected tick with its sample,
    // keeping both aligned so the sample is the raw value seen with the btn_clk rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            bclk_sync <= '0;
            raw_sync  <= '0;
            tick      <= 1'b0;
            sample    <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[1:0], btn_clk};
            raw_sync  <= {raw_sync[0], btn_raw};
            tick      <= bclk_sync[1] & ~bclk_sync[2];
            sample    <= raw_sync[1];
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            db_cnt        <= '0;
            rep_cnt       <= '0;
            first         <= 1'b0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            step_pulse    <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            db_cnt        <= db_cnt_nxt;
            rep_cnt       <= rep_cnt_nxt;
            first         <= first_nxt;
            btn_level     <= level_nxt;
            press_pulse   <= press_nxt;
            step_pulse    <= step_nxt;
            release_pulse <= release_nxt;
        end
    end

    // Next-state and next-output decode; everything holds and pulses idle without a tick.
    always_comb begin
        state_nxt   = state;
        db_cnt_nxt  = db_cnt;
        rep_cnt_nxt = rep_cnt;
        first_nxt   = first;
        level_nxt   = btn_level;
        press_nxt   = 1'b0;
        step_nxt    = 1'b0;
        release_nxt = 1'b0;
        if (tick) begin
            unique case (state)
                IDLE: begin
                    if (sample) begin
                        state_nxt  = PRESS_DB;
                        db_cnt_nxt = DB_W'(1);
                    end
                end
                PRESS_DB: begin
                    if (!sample) begin
                        state_nxt  = IDLE;
                        db_cnt_nxt = '0;
                    end else if (db_cnt == DB_LAST) begin
                        state_nxt   = HELD;
                        rep_cnt_nxt = '0;
                        first_nxt   = 1'b1;
                        level_nxt   = 1'b1;
                        press_nxt   = 1'b1;
                        step_nxt    = 1'b1;
                    end else begin
                        db_cnt_nxt = db_cnt + DB_W'(1);
                    end
                end
                HELD: begin
                    if (!sample) begin
                        // rep_cnt freezes so a rejected release glitch resumes the cadence
                        state_nxt  = RELEASE_DB;
                        db_cnt_nxt = DB_W'(1);
                    end else if (first && rep_cnt == DLY_LAST) begin
                        step_nxt    = 1'b1;
                        rep_cnt_nxt = '0;
                        first_nxt   = 1'b0;
                    end else if (!first && rep_cnt == PER_LAST) begin
                        step_nxt    = 1'b1;
                        rep_cnt_nxt = '0;
                    end else begin
                        rep_cnt_nxt = rep_cnt + REP_W'(1);
                    end
                end
                RELEASE_DB: begin
                    if (sample) begin
                        state_nxt = HELD;
                    end else if (db_cnt == DB_LAST) begin
                        state_nxt   = IDLE;
                        db_cnt_nxt  = '0;
                        level_nxt   = 1'b0;
                        release_nxt = 1'b1;
                    end else begin
                        db_cnt_nxt = db_cnt + DB_W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_btn_debounce_repeat.sv
// Self-checking bench for btn_debounce_repeat. btn_clk runs with a 20-clk period.
// A sample-level reference model predicts the pulses each tick should produce; the
// bench checks they appear exactly 4 clk after the btn_clk rise is driven, and nowhere else.
module tb_btn_debounce_repeat;

    localparam int S   = 4;
    localparam int DLY = 64;
    localparam int PER = 16;

    logic clk = 1'b0;
    logic rst, btn_clk, btn_raw;
    logic btn_level, press_pulse, step_pulse, release_pulse;

    int checks   = 0;
    int failures = 0;

    // reference model state: accepted level, run of samples opposing the level,
    // samples counted toward the next repeat, and whether the first repeat is pending
    int m_level, m_run, m_reps, m_first;

    btn_debounce_repeat #(.STABLE_SAMPLES(S), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) dut (
        .clk(clk), .rst(rst), .btn_clk(btn_clk), .btn_raw(btn_raw),
        .btn_level(btn_level), .press_pulse(press_pulse),
        .step_pulse(step_pulse), .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_level = 0; m_run = 0; m_reps = 0; m_first = 0;
    endtask

    // One button sample through the model: a change of level needs S equal samples in a
    // row; while held, repeats fire after DLY then every PER held samples, and samples
    // spent in a pending release (or the sample that cancels it) do not count.
    task automatic model_step(input int s, output int p, output int st, output int r);
        p = 0; st = 0; r = 0;
        if (m_level == 0) begin
            m_run = s ? m_run + 1 : 0;
            if (m_run == S) begin
                m_level = 1; m_run = 0; m_reps = 0; m_first = 1;
                p = 1; st = 1;
            end
        end else if (m_run > 0) begin
            if (s) m_run = 0;
            else begin
                m_run++;
                if (m_run == S) begin
                    m_level = 0; m_run = 0; r = 1;
                end
            end
        end else if (!s) begin
            m_run = 1;
        end else begin
            m_reps++;
            if (m_reps == (m_first ? DLY : PER)) begin
                st = 1; m_reps = 0; m_first = 0;
            end
        end
    endtask

    // One full btn_clk period starting at a falling clk edge; btn_raw bounces randomly
    // between sample points, which the design must ignore.
    task automatic do_tick(input int s, input string tag);
        int ep, es, er, prev_level, stray;
        prev_level = m_level;
        model_step(s, ep, es, er);
        stray = 0;
        btn_raw = s[0];
        btn_clk = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 4) begin
                check({tag, ".press"},   press_pulse,   ep);
                check({tag, ".step"},    step_pulse,    es);
                check({tag, ".release"}, release_pulse, er);
            end else begin
                stray += press_pulse + step_pulse + release_pulse;
            end
            if (i == 3) check({tag, ".level_before"}, btn_level, prev_level);
            if (i == 10) btn_clk = 1'b0;
            if (i < 20) btn_raw = 1'($urandom_range(0, 1));
        end
        check({tag, ".stray_pulse"}, stray, 0);
        check({tag, ".level"}, btn_level, m_level);
    endtask

    task automatic pulse_rst(input string tag);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check({tag, ".rst_level"}, btn_level, 0);
        check({tag, ".rst_pulses"}, press_pulse + step_pulse + release_pulse, 0);
    endtask

    initial begin
        int v, len, stray, lvl;
        rst = 1'b1; btn_clk = 1'b0; btn_raw = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset.outputs", {btn_level, press_pulse, step_pulse, release_pulse}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // short press of 3 samples is rejected
        for (int i = 0; i < 3; i++) do_tick(1, "t1_short");
        for (int i = 0; i < 3; i++) do_tick(0, "t1_idle");

        // long hold: press at tick 4, repeats at 68, 84, 100
        for (int i = 1; i <= 100; i++) do_tick(1, $sformatf("t2_hold%0d", i));

        // release glitch then real release
        do_tick(0, "t5_glitch"); do_tick(0, "t5_glitch"); do_tick(1, "t5_back");
        for (int i = 0; i < 4; i++) do_tick(0, "t5_release");

        // bounce restarts debounce
        do_tick(1, "t4_a"); do_tick(0, "t4_b");
        for (int i = 0; i < 4; i++) do_tick(1, "t4_press");

        // reset mid-held, then re-press while held
        for (int i = 0; i < 6; i++) do_tick(1, "t6_held");
        pulse_rst("t6");
        for (int i = 0; i < 6; i++) do_tick(1, "t6_repress");

        // btn_clk frozen: raw toggles but nothing moves
        stray = 0; lvl = m_level;
        for (int i = 0; i < 80; i++) begin
            btn_raw = 1'($urandom_range(0, 1));
            @(negedge clk);
            stray += press_pulse + step_pulse + release_pulse;
        end
        check("frozen.pulses", stray, 0);
        check("frozen.level", btn_level, lvl);

        // randomized runs of samples, mixing bounces and long holds
        for (int k = 0; k < 40; k++) begin
            v   = $urandom_range(0, 1);
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 6);
            for (int j = 0; j < len; j++) do_tick(v, $sformatf("rnd%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
